// File: rtl/posit_acc_ctrl.sv
// posit_acc_ctrl: sequencing front-end around an external posit_add.
// Accepts a batch of cfg_len posit operands over valid/ready, feeds each one
// to the adder together with the running sum, captures the adder result and
// presents the final sum on a valid/ready output port.
//
// Optional build macro: POSIT_ACC_ZERO_SKIP_EN
//   defined   -> an all-zero operand accepted in IDLE/ACCEPT bypasses the
//                adder; the remaining count is decremented in the accept cycle.
//   undefined -> every operand goes through the ADD state.
`default_nettype none

module posit_acc_ctrl #(
    parameter int N     = 8,
    parameter int es    = 2,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     add_in1,
    output logic [N-1:0]     add_in2,
    output logic             add_start,
    input  logic [N-1:0]     add_out,
    input  logic             add_inf,
    input  logic             add_zero,
    input  logic             add_done,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             out_inf,
    output logic             out_zero,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        ADD    = 2'd2,
        RESULT = 2'd3
    } state_t;

    // NaR: sign bit set, all other bits clear.
    localparam logic [N-1:0]     NAR     = {1'b1, {(N-1){1'b0}}};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    // es is only meaningful to the adder; reject widths that cannot form a
    // posit of N bits (sign + at least two regime bits + exponent).
    if (es < 0 || es > N - 3) begin : g_es_range_bad
        $error("posit_acc_ctrl: es=%0d out of range for N=%0d", es, N);
    end

    state_t           state_q, state_d;
    logic [N-1:0]     acc_q,   acc_d;
    logic [N-1:0]     opnd_q,  opnd_d;
    logic [LEN_W-1:0] rem_q,   rem_d;
    logic             inf_q,   inf_d;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] rem_base;
    logic             in_is_zero;
    logic             in_fire;
    logic [N-1:0]     add_result;

    // A zero batch length is treated as a single-operand batch.
    assign len_eff = (cfg_len == '0) ? LEN_ONE : cfg_len;

    // Remaining count in effect for an operand accepted this cycle: a fresh
    // batch starts from the configured length, later operands from rem_q.
    assign rem_base = (state_q == IDLE) ? len_eff : rem_q;

`ifdef POSIT_ACC_ZERO_SKIP_EN
    assign in_is_zero = (in_data == '0);
`else
    assign in_is_zero = 1'b0;
`endif

    // Adder flags win over the raw word so the accumulator always holds a
    // canonical NaR / zero encoding even if out is loosely defined then.
    assign add_result = add_inf  ? NAR :
                        add_zero ? '0  : add_out;

    assign in_fire = in_valid && in_ready;

    // Operands to the adder come straight from the registers so they stay
    // stable for as long as a multicycle adder keeps done low.
    assign add_in1 = acc_q;
    assign add_in2 = opnd_q;
    assign busy    = (state_q != IDLE);

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        inf_d     = inf_q;
        in_ready  = 1'b0;
        add_start = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_inf   = 1'b0;
        out_zero  = 1'b0;

        case (state_q)
            IDLE, ACCEPT: begin
                in_ready = 1'b1;
                if (state_q == IDLE) begin
                    // Nothing in flight: keep the sum cleared for the next batch.
                    acc_d = '0;
                    inf_d = 1'b0;
                end
                if (in_fire) begin
                    opnd_d = in_data;
                    if (in_is_zero) begin
                        // Adding zero cannot change the sum: retire the
                        // operand here without touching the adder.
                        rem_d   = rem_base - LEN_ONE;
                        state_d = (rem_base == LEN_ONE) ? RESULT : ACCEPT;
                    end else begin
                        rem_d   = rem_base;
                        state_d = ADD;
                    end
                end
            end

            ADD: begin
                if (inf_q) begin
                    // NaR absorbs everything: skip the adder for the rest
                    // of the batch but keep consuming operands.
                    acc_d   = NAR;
                    rem_d   = rem_q - LEN_ONE;
                    state_d = (rem_q == LEN_ONE) ? RESULT : ACCEPT;
                end else begin
                    add_start = 1'b1;
                    if (add_done) begin
                        acc_d   = add_result;
                        inf_d   = inf_q | add_inf;
                        rem_d   = rem_q - LEN_ONE;
                        state_d = (rem_q == LEN_ONE) ? RESULT : ACCEPT;
                    end
                end
            end

            RESULT: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                out_inf   = inf_q;
                out_zero  = (acc_q == '0);
                if (out_ready) begin
                    acc_d   = '0;
                    inf_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any batch in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            inf_q   <= inf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_posit_acc_ctrl.sv
// Directed bench for posit_acc_ctrl with a small posit8/es=2 adder stand-in
// whose latency (cycles from start to done) is adjustable.
`timescale 1ns/1ps

module tb_posit_acc_ctrl;

    localparam int N     = 8;
    localparam int ES    = 2;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic [N-1:0]     add_in1;
    logic [N-1:0]     add_in2;
    logic             add_start;
    logic [N-1:0]     add_out;
    logic             add_inf;
    logic             add_zero;
    logic             add_done;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_inf;
    logic             out_zero;
    logic             out_ready;
    logic             busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int starts = 0;
    int acnt   = 0;
    int adder_lat = 1;

    posit_acc_ctrl #(.N(N), .es(ES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_out(add_out), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .out_valid(out_valid), .out_data(out_data), .out_inf(out_inf),
        .out_zero(out_zero), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in posit8 es=2 adder covering the sums this bench uses:
    // 1.0=0x40, 2.0=0x48, 3.0=0x4C, NaR=0x80.
    function automatic logic [7:0] padd(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h80 || b == 8'h80)                  return 8'h80;
        if (a == 8'h00)                                return b;
        if (b == 8'h00)                                return a;
        if (a == 8'h40 && b == 8'h40)                  return 8'h48;
        if ((a == 8'h48 && b == 8'h40) || (a == 8'h40 && b == 8'h48)) return 8'h4C;
        return 8'h7F;
    endfunction

    assign add_out  = padd(add_in1, add_in2);
    assign add_inf  = (add_out == 8'h80);
    assign add_zero = (add_out == 8'h00);
    assign add_done = add_start && (acnt == adder_lat - 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (add_start && add_done) starts <= starts + 1;
        if (add_start && !add_done) acnt <= acnt + 1;
        else                        acnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand and return at the falling edge after it is taken.
    task automatic send(input logic [7:0] d);
        int k;
        in_data  = d;
        in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (k == 50) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Run a batch of n operands and wait for out_valid. lat counts cycles
    // from the first accept cycle (index 0) to the first out_valid cycle.
    task automatic run_batch(input int n, input logic [7:0] len,
                             input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2,
                             output int lat, output int pulses);
        int base;
        int acc_cyc;
        int k;
        base    = starts;
        acc_cyc = 0;
        cfg_len = len;
        for (int i = 0; i < n; i++) begin
            send((i == 0) ? o0 : (i == 1) ? o1 : o2);
            if (i == 0) acc_cyc = cyc;
        end
        for (k = 0; k < 100; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        if (k == 100) check("result_timeout", 32'd1, 32'd0);
        lat    = cyc - acc_cyc + 1;
        pulses = starts - base;
    endtask

    // Consume the result and confirm the block is back in IDLE.
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        rst = 1'b1; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_add_in1", 32'(add_in1), 32'h00);
        check("rst_add_in2", 32'(add_in2), 32'h00);
        $display("txn reset: in_ready=%0d busy=%0d", in_ready, busy);

        // 1.0 + 1.0 + 1.0 = 3.0
        run_batch(3, 8'd3, 8'h40, 8'h40, 8'h40, lat, pulses);
        $display("txn sum3: data=0x%02h inf=%0d lat=%0d pulses=%0d", out_data, out_inf, lat, pulses);
        check("sum3_data", 32'(out_data), 32'h4C);
        check("sum3_inf", 32'(out_inf), 32'd0);
        check("sum3_zero", 32'(out_zero), 32'd0);
        check("sum3_lat", 32'(lat), 32'd6);
        check("sum3_pulses", 32'(pulses), 32'd3);
        check("sum3_in_ready", 32'(in_ready), 32'd0);
        take("sum3");

        // Back-pressure on the result port
        run_batch(2, 8'd2, 8'h40, 8'h40, 8'h00, lat, pulses);
        $display("txn hold: data=0x%02h lat=%0d", out_data, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", 32'(out_data), 32'h48);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        take("hold");

        // NaR is sticky; third operand bypasses the adder
        run_batch(3, 8'd3, 8'h40, 8'h80, 8'h40, lat, pulses);
        $display("txn nar: data=0x%02h inf=%0d pulses=%0d", out_data, out_inf, pulses);
        check("nar_data", 32'(out_data), 32'h80);
        check("nar_inf", 32'(out_inf), 32'd1);
        check("nar_zero", 32'(out_zero), 32'd0);
        check("nar_pulses", 32'(pulses), 32'd2);
        check("nar_lat", 32'(lat), 32'd6);
        take("nar");

        // cfg_len = 0 behaves as length 1
        run_batch(1, 8'd0, 8'h48, 8'h00, 8'h00, lat, pulses);
        $display("txn len0: data=0x%02h lat=%0d pulses=%0d", out_data, lat, pulses);
        check("len0_data", 32'(out_data), 32'h48);
        check("len0_inf", 32'(out_inf), 32'd0);
        check("len0_lat", 32'(lat), 32'd2);
        check("len0_pulses", 32'(pulses), 32'd1);
        take("len0");

        // Reset after the first of three operands has been added
        cfg_len = 8'd3;
        send(8'h40);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_batch(1, 8'd1, 8'h40, 8'h00, 8'h00, lat, pulses);
        $display("txn midrst: data=0x%02h lat=%0d", out_data, lat);
        check("midrst_data", 32'(out_data), 32'h40);
        check("midrst_lat", 32'(lat), 32'd2);
        take("midrst");

        // Zero operand first in a batch of two
        run_batch(2, 8'd2, 8'h00, 8'h40, 8'h00, lat, pulses);
        $display("txn zskip: data=0x%02h lat=%0d pulses=%0d", out_data, lat, pulses);
        check("zskip_data", 32'(out_data), 32'h40);
        check("zskip_zero", 32'(out_zero), 32'd0);
`ifdef POSIT_ACC_ZERO_SKIP_EN
        check("zskip_pulses", 32'(pulses), 32'd1);
        check("zskip_lat", 32'(lat), 32'd3);
`else
        check("zskip_pulses", 32'(pulses), 32'd2);
        check("zskip_lat", 32'(lat), 32'd4);
`endif
        take("zskip");

        // Single zero operand gives a zero result
        run_batch(1, 8'd1, 8'h00, 8'h00, 8'h00, lat, pulses);
        $display("txn zero: data=0x%02h zero=%0d lat=%0d", out_data, out_zero, lat);
        check("zero_data", 32'(out_data), 32'h00);
        check("zero_flag", 32'(out_zero), 32'd1);
`ifdef POSIT_ACC_ZERO_SKIP_EN
        check("zero_lat", 32'(lat), 32'd1);
`else
        check("zero_lat", 32'(lat), 32'd2);
`endif
        take("zero");

        // Three-cycle adder: ADD must hold until done
        adder_lat = 3;
        run_batch(2, 8'd2, 8'h40, 8'h40, 8'h00, lat, pulses);
        $display("txn slow: data=0x%02h lat=%0d pulses=%0d", out_data, lat, pulses);
        check("slow_data", 32'(out_data), 32'h48);
        check("slow_lat", 32'(lat), 32'd8);
        check("slow_pulses", 32'(pulses), 32'd2);
        take("slow");
        adder_lat = 1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
